but_led_ctrl: RTL and testbench



---
 rtl/but_led_ctrl.sv | 108 ++++++++++
 tb/tb_but_led_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/but_led_ctrl.sv
// Multi-channel button-to-LED controller: per channel a 2-flop synchroniser,
// a counting debouncer, a registered press strobe and a follow/toggle/pulse LED driver.
module but_led_ctrl #(
  parameter int CHANNELS        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MODE            = 1,
  parameter int PULSE_CYCLES    = 8,
  parameter int BUT_ACTIVE_LOW  = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] BUT,
  output logic [CHANNELS-1:0] LED,
  output logic [CHANNELS-1:0] PRESS
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] POL_MASK = (BUT_ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : '0;

  if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || MODE < 0 || MODE > 2 || PULSE_CYCLES < 1 ||
      (BUT_ACTIVE_LOW != 0 && BUT_ACTIVE_LOW != 1)) begin : g_bad_param
    $error("but_led_ctrl: parameter out of range");
  end

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  logic [CHANNELS-1:0] sync_p0, sync_p1;
  logic [CHANNELS-1:0] s_p2;
  logic [CW-1:0]       cnt_p2 [CHANNELS];
  logic [CHANNELS-1:0] rise_p2;
  logic [CHANNELS-1:0] s_p3;

  // p0/p1: synchroniser, p2: debounced stable level
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      s_p2    <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= BUT ^ POL_MASK;
      sync_p1 <= sync_p0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (sync_p1[i] == s_p2[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          s_p2[i]   <= sync_p1[i];
          cnt_p2[i] <= '0;
        end else begin
          cnt_p2[i] <= cnt_p2[i] + 1'b1;
        end
      end
    end
  end

  assign rise_p2 = s_p2 & ~s_p3;

  // p3: press strobe and LED drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      s_p3  <= '0;
      PRESS <= '0;
    end else begin
      s_p3  <= s_p2;
      PRESS <= rise_p2;
    end
  end

  if (MODE == 0) begin : g_follow
    always_ff @(posedge CLK) begin
      if (RST) LED <= '0;
      else     LED <= s_p2;
    end
  end else if (MODE == 1) begin : g_toggle
    always_ff @(posedge CLK) begin
      if (RST) LED <= '0;
      else     LED <= LED ^ rise_p2;
    end
  end else begin : g_pulse
    localparam logic [TW-1:0] TMR_LOAD = TW'(PULSE_CYCLES);
    logic [TW-1:0] tmr_p3  [CHANNELS];
    logic [TW-1:0] tmr_nxt [CHANNELS];

    // A press always reloads, so a retrigger on the last lit cycle leaves no dark gap.
    always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
        tmr_nxt[i] = rise_p2[i] ? TMR_LOAD : dec_sat(tmr_p3[i]);
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        LED <= '0;
        for (int i = 0; i < CHANNELS; i++) tmr_p3[i] <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) begin
          tmr_p3[i] <= tmr_nxt[i];
          LED[i]    <= (tmr_nxt[i] != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_but_led_ctrl.sv
// Bench for but_led_ctrl: three instances (follow/active-low, toggle, pulse) driven by
// segment tables and hand sequences; expected outputs queued per cycle and checked on negedge.
module tb_but_led_ctrl;

  logic       clk = 1'b0;
  logic       rst0, rst1, rst2;
  logic [3:0] but0;
  logic [1:0] but1, but2;
  logic [3:0] led0, press0;
  logic [1:0] led1, press1, led2, press2;

  but_led_ctrl #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .MODE(0), .PULSE_CYCLES(8), .BUT_ACTIVE_LOW(1))
    u_follow (.CLK(clk), .RST(rst0), .BUT(but0), .LED(led0), .PRESS(press0));

  but_led_ctrl #(.CHANNELS(2), .DEBOUNCE_CYCLES(4), .MODE(1), .PULSE_CYCLES(8), .BUT_ACTIVE_LOW(0))
    u_toggle (.CLK(clk), .RST(rst1), .BUT(but1), .LED(led1), .PRESS(press1));

  but_led_ctrl #(.CHANNELS(2), .DEBOUNCE_CYCLES(2), .MODE(2), .PULSE_CYCLES(8), .BUT_ACTIVE_LOW(0))
    u_pulse (.CLK(clk), .RST(rst2), .BUT(but2), .LED(led2), .PRESS(press2));

  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic       rst;
    logic [3:0] but;
    int         n;
    logic [3:0] led;
    logic [3:0] press;
  } seg_t;

  typedef struct {
    int         sel;
    int         id;
    int         tick;
    logic [3:0] led;
    logic [3:0] press;
  } exp_t;

  exp_t       sb[$];
  seg_t       tbl_a[$];
  seg_t       tbl_b[$];
  int         checks = 0;
  int         failures = 0;
  int         seg_id = 0;
  exp_t       ce;
  logic [3:0] gl, gp;

  function automatic seg_t mk(input int sel, input logic rst, input logic [3:0] but, input int n,
                              input logic [3:0] led, input logic [3:0] press);
    seg_t r;
    r.sel = sel; r.rst = rst; r.but = but; r.n = n; r.led = led; r.press = press;
    return r;
  endfunction

  task automatic drive(input int sel, input logic rst, input logic [3:0] but);
    case (sel)
      0:       begin rst0 = rst; but0 = but;      end
      1:       begin rst1 = rst; but1 = but[1:0]; end
      default: begin rst2 = rst; but2 = but[1:0]; end
    endcase
  endtask

  // Hold inputs for n edges; each edge queues the outputs expected right after it.
  task automatic seg(input int sel, input logic rst, input logic [3:0] but, input int n,
                     input logic [3:0] led, input logic [3:0] press);
    exp_t e;
    seg_id++;
    drive(sel, rst, but);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      e.sel = sel; e.id = seg_id; e.tick = k + 1; e.led = led; e.press = press;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      ce = sb.pop_front();
      case (ce.sel)
        0:       begin gl = led0;          gp = press0;          end
        1:       begin gl = {2'b00, led1}; gp = {2'b00, press1}; end
        default: begin gl = {2'b00, led2}; gp = {2'b00, press2}; end
      endcase
      checks++;
      if ({gl, gp} !== {ce.led, ce.press}) begin
        failures++;
        $display("FAIL seg%0d tick%0d dut%0d: led=%b press=%b, expected led=%b press=%b",
                 ce.id, ce.tick, ce.sel, gl, gp, ce.led, ce.press);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    but0 = 4'hF; but1 = 2'b00; but2 = 2'b00;

    // Toggle channel: reset with buttons held, fresh press, glitch filter, 4-sample boundary
    tbl_a.push_back(mk(1, 1'b1, 4'h3,  3, 4'h0, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h3,  6, 4'h0, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h3,  1, 4'h3, 4'h3));
    tbl_a.push_back(mk(1, 1'b0, 4'h3,  5, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h0, 16, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h2,  3, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h0, 12, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h2,  4, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h0,  2, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h0,  1, 4'h1, 4'h2));
    tbl_a.push_back(mk(1, 1'b0, 4'h0, 12, 4'h1, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h2,  6, 4'h1, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h2,  1, 4'h3, 4'h2));
    tbl_a.push_back(mk(1, 1'b0, 4'h2,  3, 4'h3, 4'h0));
    tbl_a.push_back(mk(1, 1'b0, 4'h0, 14, 4'h3, 4'h0));

    // After bounce settles high: one press; then two clean toggles on channel 0
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  6, 4'h3, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  1, 4'h2, 4'h1));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  5, 4'h2, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h0, 12, 4'h2, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  6, 4'h2, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  1, 4'h3, 4'h1));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  3, 4'h3, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h0, 20, 4'h3, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  6, 4'h3, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  1, 4'h2, 4'h1));
    tbl_b.push_back(mk(1, 1'b0, 4'h1,  5, 4'h2, 4'h0));
    tbl_b.push_back(mk(1, 1'b0, 4'h0, 12, 4'h2, 4'h0));
    // Follow channel, active-low, 4 channels
    tbl_b.push_back(mk(0, 1'b1, 4'hF,  2, 4'h0, 4'h0));
    tbl_b.push_back(mk(0, 1'b0, 4'h5,  6, 4'h0, 4'h0));
    tbl_b.push_back(mk(0, 1'b0, 4'h5,  1, 4'hA, 4'hA));
    tbl_b.push_back(mk(0, 1'b0, 4'h5,  5, 4'hA, 4'h0));
    tbl_b.push_back(mk(0, 1'b0, 4'hF,  6, 4'hA, 4'h0));
    tbl_b.push_back(mk(0, 1'b0, 4'hF,  1, 4'h0, 4'h0));
    tbl_b.push_back(mk(0, 1'b0, 4'hF,  5, 4'h0, 4'h0));

    for (int i = 0; i < tbl_a.size(); i++)
      seg(tbl_a[i].sel, tbl_a[i].rst, tbl_a[i].but, tbl_a[i].n, tbl_a[i].led, tbl_a[i].press);

    // Bounce: channel 0 toggles every cycle, never stable long enough
    for (int i = 0; i < 20; i++)
      seg(1, 1'b0, {3'b000, ~i[0]}, 1, 4'h3, 4'h0);

    for (int i = 0; i < tbl_b.size(); i++)
      seg(tbl_b[i].sel, tbl_b[i].rst, tbl_b[i].but, tbl_b[i].n, tbl_b[i].led, tbl_b[i].press);

    // Pulse mode (debounce 2, press on edge 5): single press lights exactly 8 cycles
    seg(2, 1'b1, 4'h0, 2, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h1, 4, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h1, 1, 4'h1, 4'h1);
    seg(2, 1'b0, 4'h1, 3, 4'h1, 4'h0);
    seg(2, 1'b0, 4'h0, 4, 4'h1, 4'h0);
    seg(2, 1'b0, 4'h0, 1, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h0, 8, 4'h0, 4'h0);

    // Retrigger in the 6th lit cycle: 13 lit cycles with no gap
    seg(2, 1'b0, 4'h1, 2, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h0, 2, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h0, 1, 4'h1, 4'h1);
    seg(2, 1'b0, 4'h1, 4, 4'h1, 4'h0);
    seg(2, 1'b0, 4'h1, 1, 4'h1, 4'h1);
    seg(2, 1'b0, 4'h1, 7, 4'h1, 4'h0);
    seg(2, 1'b0, 4'h1, 1, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h1, 5, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h0, 8, 4'h0, 4'h0);

    // Reset during the pulse darkens the LED on the next edge
    seg(2, 1'b0, 4'h1, 4, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h1, 1, 4'h1, 4'h1);
    seg(2, 1'b0, 4'h1, 2, 4'h1, 4'h0);
    seg(2, 1'b1, 4'h0, 2, 4'h0, 4'h0);
    seg(2, 1'b0, 4'h0, 8, 4'h0, 4'h0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
